// File: rtl/edge_pkg.sv
// Shared edge-mode encoding for the edge detector bank.
// Also holds the direction qualifier used by every channel.
package edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // new_lvl is the level being entered: 1 means a rising edge.
    function automatic logic edge_enabled(
        input logic [1:0] mode,
        input logic       new_lvl
    );
        logic en;
        en = 1'b0;
        unique case (mode)
            MODE_OFF:  en = 1'b0;
            MODE_RISE: en = new_lvl;
            MODE_FALL: en = ~new_lvl;
            MODE_BOTH: en = 1'b1;
            default:   en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, debounce filter, qualified edge pulse,
// sticky pending flag and saturating event counter.
module edge_det_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             pulse_o,
    output logic             pend_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          deb_q, deb_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   pend_q, pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   s;
    logic                   fire;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        deb_d   = '0;
        level_d = level_q;
        fire    = 1'b0;
        if (s != level_q) begin
            if (deb_q == DEB_LAST) begin
                level_d = s;
                fire    = 1'b1;
            end else begin
                deb_d = deb_q + 1'b1;
            end
        end
        pulse_d = fire & edge_enabled(mode_i, s);
        // A pulse on the clearing edge wins so the event is not lost.
        pend_d  = pulse_d | (pend_q & ~clr_i);
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = CNT_W'(pulse_d);
        end else if (pulse_d && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            deb_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            deb_q   <= deb_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign pend_o  = pend_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/edge_detector_bank.sv
// Bank of N_CH debounced edge detectors with a registered
// counter read port and a combined pending indication.
module edge_detector_bank
    import edge_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int DEB_CYCLES  = 4,
    parameter  int CNT_W       = 8,
    localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   sig_i,
    input  logic [2*N_CH-1:0] mode_i,
    input  logic [N_CH-1:0]   clr_i,
    input  logic [SEL_W-1:0]  cnt_sel_i,
    output logic [N_CH-1:0]   level_o,
    output logic [N_CH-1:0]   pulse_o,
    output logic [N_CH-1:0]   pend_o,
    output logic              any_pend_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [CNT_W-1:0] cnt_w [N_CH];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sig_i   (sig_i[c]),
            .mode_i  (mode_i[2*c+1:2*c]),
            .clr_i   (clr_i[c]),
            .level_o (level_o[c]),
            .pulse_o (pulse_o[c]),
            .pend_o  (pend_o[c]),
            .cnt_o   (cnt_w[c])
        );
    end

    // Out-of-range selects match no channel and read as zero.
    always_comb begin
        cnt_d = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cnt_sel_i == SEL_W'(c)) begin
                cnt_d = cnt_w[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign any_pend_o = |pend_o;

endmodule

// File: doc/edge_detector_bank.md
EDGE_DETECTOR_BANK -- requirements
Module: edge_detector_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (>=2).
REQ-003 SHALL have parameter DEB_CYCLES, default 4, consecutive stable cycles required before the filtered level changes (>=1).
REQ-004 SHALL have parameter CNT_W, default 8, per-channel event counter width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port sig_i, input, N_CH, asynchronous raw inputs.
REQ-008 SHALL have port mode_i, input, 2*N_CH, per-channel edge mode, bits [2c+1:2c] for channel c.
REQ-009 SHALL have port clr_i, input, N_CH, per-channel clear of pending flag and counter.
REQ-010 SHALL have port cnt_sel_i, input, max(1,clog2(N_CH)), counter read select.
REQ-011 SHALL have port level_o, output, N_CH, debounced level.
REQ-012 SHALL have port pulse_o, output, N_CH, one-cycle qualified edge pulse.
REQ-013 SHALL have port pend_o, output, N_CH, sticky event-pending flags.
REQ-014 SHALL have port any_pend_o, output, 1, OR of pend_o.
REQ-015 SHALL have port cnt_o, output, CNT_W, selected channel's event count.

Function
REQ-016 SHALL pass each sig_i bit through a SYNC_STAGES-deep flop chain; the last stage is the synchronised value s.
REQ-017 SHALL keep a per-channel debounce counter: cleared when s == level; incremented when s != level; when s != level and counter == DEB_CYCLES-1, level takes s and counter clears.
REQ-018 SHALL update level_o exactly SYNC_STAGES+DEB_CYCLES-1 edges after the first edge sampling a new stable sig_i value; a glitch shorter than DEB_CYCLES synchronised cycles SHALL NOT change level_o.
REQ-019 SHALL encode mode as 00 off, 01 rising, 10 falling, 11 both.
REQ-020 SHALL assert pulse_o[c] (registered) for exactly one cycle, the same cycle level_o[c] first shows the new value, iff the transition direction is enabled by mode_i[c] sampled on the updating edge.
REQ-021 SHALL track level regardless of mode; mode changes affect only pulse qualification from the next edge.
REQ-022 SHALL set pend_o[c] on any cycle pulse_o[c] is asserted and hold it until clr_i[c]; simultaneous pulse and clr SHALL leave pend_o[c]=1.
REQ-023 SHALL increment counter c on each pulse_o[c], saturating at 2^CNT_W-1; clr_i[c] zeroes it; simultaneous pulse and clr SHALL yield count 1.
REQ-024 SHALL present cnt_o registered, one cycle after cnt_sel_i, reflecting the count value held before that edge; cnt_sel_i >= N_CH SHALL yield 0.
REQ-025 SHALL drive any_pend_o combinationally from pend_o.

Reset
REQ-026 SHALL, on rst sampled high, clear all sync flops, debounce counters, level_o, pulse_o, pend_o, event counters and cnt_o to 0.
REQ-027 SHALL, with reset asserted mid-debounce, discard the partial count; an input held high through reset release SHALL produce a rising pulse after the REQ-018 latency.

Structure
REQ-028 SHALL place the mode encoding constants (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) in a shared package edge_pkg.
REQ-029 SHALL implement one channel (sync, debounce, pulse, flag, counter) as sub-module edge_det_channel, instantiated N_CH times; read mux and any_pend_o in the top.

Verification
REQ-030 SHALL check: defaults, mode 01, sig_i[0] 0->1 at edge 0 and held -> level_o[0]=1 and pulse_o[0]=1 for one cycle after edge 5; pend_o[0]=1; cnt_o=1 with cnt_sel_i=0.
REQ-031 SHALL check: 3-cycle high glitch on sig_i[1] -> level_o[1], pulse_o[1] stay 0, count stays 0.
REQ-032 SHALL check: mode 10 on channel 2, full 0->1->0 cycle -> level_o follows, exactly one pulse (falling), count 1; mode 11 gives count 2.
REQ-033 SHALL check: CNT_W=4, 20 qualified edges -> cnt_o saturates at 15; clr_i coincident with pulse -> count 1, pend_o stays 1.
REQ-034 SHALL check: rst asserted 2 cycles into debounce with input high -> all outputs 0 next cycle, rising pulse 5 edges after reset deasserts.
